// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GRP_W = 4;

    function automatic int slice_cnt(input int width, input int slice_w);
        return width / slice_w;
    endfunction

    function automatic bit params_ok(input int width, input int slice_w);
        return (slice_w >= GRP_W) && (slice_w % GRP_W == 0) &&
               (width >= slice_w) && (width % slice_w == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate for chaining.
module cla_group
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] s,
    output logic             pg,
    output logic             gg,
    output logic             cout
);

    logic [GRP_W-1:0] g, p;
    logic [GRP_W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GRP_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s  = p ^ c[GRP_W-1:0];
        pg = &p;
        gg = 1'b0;
        for (int i = 0; i < GRP_W; i++) begin
            gg = g[i] | (p[i] & gg);
        end
        cout = c[GRP_W];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one SLICE_W slice per stage, slice carry registered between stages,
// valid/ready on both sides with bubble collapsing.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LAT = slice_cnt(WIDTH, SLICE_W);
    localparam int NG  = SLICE_W / GRP_W;
    localparam int MSB = WIDTH - 1;

    if (!params_ok(WIDTH, SLICE_W)) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a multiple of SLICE_W, SLICE_W a multiple of 4");
    end

    logic [LAT-1:0]            vld_q;
    logic [LAT-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [LAT-1:0]            c_q;
    logic                      ovf_q;

    logic [LAT:0]              vnx, adv;
    logic [LAT-1:0]            load;
    logic [LAT-1:0][WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [LAT-1:0]            c_in, v_in, c_d;
    logic                      ovf_d;

    // A stage advances when the stage after it is empty or itself advancing.
    assign vnx = {1'b1, vld_q};

    always_comb begin
        adv      = '0;
        adv[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & (~vnx[k+1] | adv[k+1]);
        end
    end

    assign load      = ~vld_q | adv[LAT-1:0];
    assign in_ready  = load[0];
    assign out_valid = vld_q[LAT-1];

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        logic [NG-1:0]      gp, gg, gco, gc;
        logic [SLICE_W-1:0] ss;

        if (k == 0) begin : g_head
            assign a_in[k] = in_a;
            assign b_in[k] = in_sub ? ~in_b : in_b;
            assign c_in[k] = in_sub | in_cin;
            assign s_in[k] = '0;
            assign v_in[k] = in_valid;
        end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign v_in[k] = vld_q[k-1];
        end

        assign gc[0] = c_in[k];
        for (genvar j = 1; j < NG; j++) begin : g_chain
            assign gc[j] = gg[j-1] | (gp[j-1] & gc[j-1]);
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group u_grp (
                .a    (a_in[k][k*SLICE_W + j*GRP_W +: GRP_W]),
                .b    (b_in[k][k*SLICE_W + j*GRP_W +: GRP_W]),
                .cin  (gc[j]),
                .s    (ss[j*GRP_W +: GRP_W]),
                .pg   (gp[j]),
                .gg   (gg[j]),
                .cout (gco[j])
            );
        end

        // Slice k of the partial sum is still zero on entry, so OR-ing it in is enough.
        assign s_d[k] = s_in[k] | (WIDTH'(ss) << (k * SLICE_W));
        assign c_d[k] = gco[NG-1];
    end

    // Carry into the MSB recovered from the MSB's own sum bit.
    assign ovf_d = (a_in[LAT-1][MSB] ^ b_in[LAT-1][MSB] ^ s_d[LAT-1][MSB]) ^ c_d[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (load[k]) begin
                    vld_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (load[LAT-1] && v_in[LAT-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_sum  = s_q[LAT-1];
    assign out_cout = c_q[LAT-1];
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Random and directed checks of cla_pipe_adder at 32/8, 8/8 and 64/4 against an arithmetic model.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_iv, m_ir, m_cin, m_sub, m_ovld, m_or, m_co, m_ovf;
    logic [31:0] m_a, m_b, m_s;
    logic        c8_iv, c8_ir, c8_cin, c8_sub, c8_ovld, c8_or, c8_co, c8_ovf;
    logic [7:0]  c8_a, c8_b, c8_s;
    logic        c64_iv, c64_ir, c64_cin, c64_sub, c64_ovld, c64_or, c64_co, c64_ovf;
    logic [63:0] c64_a, c64_b, c64_s;

    cla_pipe_adder #(.WIDTH(32), .SLICE_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .in_a(m_a), .in_b(m_b),
        .in_cin(m_cin), .in_sub(m_sub), .out_valid(m_ovld), .out_ready(m_or),
        .out_sum(m_s), .out_cout(m_co), .out_ovf(m_ovf));

    cla_pipe_adder #(.WIDTH(8), .SLICE_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(c8_iv), .in_ready(c8_ir), .in_a(c8_a), .in_b(c8_b),
        .in_cin(c8_cin), .in_sub(c8_sub), .out_valid(c8_ovld), .out_ready(c8_or),
        .out_sum(c8_s), .out_cout(c8_co), .out_ovf(c8_ovf));

    cla_pipe_adder #(.WIDTH(64), .SLICE_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(c64_iv), .in_ready(c64_ir), .in_a(c64_a), .in_b(c64_b),
        .in_cin(c64_cin), .in_sub(c64_sub), .out_valid(c64_ovld), .out_ready(c64_or),
        .out_sum(c64_s), .out_cout(c64_co), .out_ovf(c64_ovf));

    res_t q_m[$], q_8[$], q_64[$];
    int   total = 0, bad = 0;
    int   m_pops = 0, c8_pops = 0, c64_pops = 0;
    logic m_acc, m_pop, corner_run;

    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] mask, aa, bb;
        logic [64:0] full;
        res_t        r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
        r.s  = full[63:0] & mask;
        r.co = full[w];
        r.ov = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
        return r;
    endfunction

    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task chk_res(input string tag, input res_t e, input logic [63:0] s, input logic co, input logic ov);
        chk({tag, "_sum"}, s, e.s);
        chk({tag, "_cout"}, 64'(co), 64'(e.co));
        chk({tag, "_ovf"}, 64'(ov), 64'(e.ov));
    endtask

    // One clock: record handshakes that the coming edge will perform, then refresh corner stimulus.
    task step();
        res_t e;
        #1;
        m_acc = m_iv && m_ir;
        m_pop = m_ovld && m_or;
        if (m_acc) q_m.push_back(model(32, 64'(m_a), 64'(m_b), m_cin, m_sub));
        if (m_pop) begin
            m_pops++;
            if (q_m.size() == 0) chk("m_spurious", 1, 0);
            else begin e = q_m.pop_front(); chk_res("m", e, 64'(m_s), m_co, m_ovf); end
        end
        if (c8_iv && c8_ir) q_8.push_back(model(8, 64'(c8_a), 64'(c8_b), c8_cin, c8_sub));
        if (c8_ovld && c8_or) begin
            c8_pops++;
            if (q_8.size() == 0) chk("c8_spurious", 1, 0);
            else begin e = q_8.pop_front(); chk_res("c8", e, 64'(c8_s), c8_co, c8_ovf); end
        end
        if (c64_iv && c64_ir) q_64.push_back(model(64, c64_a, c64_b, c64_cin, c64_sub));
        if (c64_ovld && c64_or) begin
            c64_pops++;
            if (q_64.size() == 0) chk("c64_spurious", 1, 0);
            else begin e = q_64.pop_front(); chk_res("c64", e, c64_s, c64_co, c64_ovf); end
        end
        @(posedge clk);
        #1;
        c8_a  = 8'($urandom);  c8_b  = 8'($urandom);
        c8_cin = 1'($urandom_range(0, 1));  c8_sub = 1'($urandom_range(0, 1));
        c64_a = {$urandom, $urandom};  c64_b = {$urandom, $urandom};
        c64_cin = 1'($urandom_range(0, 1)); c64_sub = 1'($urandom_range(0, 1));
        c8_iv  = corner_run && ($urandom_range(0, 3) != 0);
        c64_iv = corner_run && ($urandom_range(0, 3) != 0);
        c8_or  = !corner_run || ($urandom_range(0, 3) != 0);
        c64_or = !corner_run || ($urandom_range(0, 3) != 0);
        @(negedge clk);
    endtask

    task rand_main();
        m_a = $urandom; m_b = $urandom;
        m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge: asserts reset, checks outputs at once, releases two cycles later.
    task do_reset(input string tag);
        m_iv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_ovalid"}, 64'(m_ovld), 0);
        chk({tag, "_sum"}, 64'(m_s), 0);
        chk({tag, "_cout"}, 64'(m_co), 0);
        chk({tag, "_ovf"}, 64'(m_ovf), 0);
        chk({tag, "_c8_ovalid"}, 64'(c8_ovld), 0);
        chk({tag, "_c64_ovalid"}, 64'(c64_ovld), 0);
        q_m.delete(); q_8.delete(); q_64.delete();
        repeat (2) @(negedge clk);
        chk({tag, "_iready"}, 64'(m_ir), 1);
        rst_n = 1'b1;
    endtask

    task one_beat(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                  input logic sub, input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_iv = 1'b1; m_or = 1'b1;
        step();
        m_iv = 1'b0;
        lat = 1;
        while (!m_ovld && lat < 20) begin step(); lat++; end
        chk({tag, "_lat"}, 64'(lat), 4);
        chk({tag, "_sum"}, 64'(m_s), 64'(es));
        chk({tag, "_cout"}, 64'(m_co), 64'(eco));
        chk({tag, "_ovf"}, 64'(m_ovf), 64'(eov));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   stalls, gaps, acc, p0, n;
        logic [31:0] held;
        res_t e;
        m_iv = 0; m_or = 1; m_a = 0; m_b = 0; m_cin = 0; m_sub = 0;
        c8_iv = 0; c8_or = 1; c8_a = 0; c8_b = 0; c8_cin = 0; c8_sub = 0;
        c64_iv = 0; c64_or = 1; c64_a = 0; c64_b = 0; c64_cin = 0; c64_sub = 0;
        corner_run = 1'b1;
        @(negedge clk);
        do_reset("rst");

        one_beat("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        one_beat("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        one_beat("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // back-to-back stream, sink always ready
        stalls = 0; gaps = 0; p0 = m_pops; m_or = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_main(); m_iv = 1'b1;
            step();
            if (!m_acc) stalls++;
            if (i >= 4 && !m_pop) gaps++;
        end
        m_iv = 1'b0;
        n = 0;
        while (q_m.size() != 0 && n < 20) begin step(); n++; end
        chk("stream_stalls", 64'(stalls), 0);
        chk("stream_gaps", 64'(gaps), 0);
        chk("stream_pops", 64'(m_pops - p0), 100);

        // backpressure: sink stalled for 10 cycles while pushing
        acc = 0; held = '0; p0 = m_pops; m_or = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_main(); m_iv = 1'b1;
            step();
            if (m_acc) acc++;
            if (i == 5) held = m_s;
        end
        #1;
        chk("bp_accepted", 64'(acc), 4);
        chk("bp_iready", 64'(m_ir), 0);
        chk("bp_ovalid", 64'(m_ovld), 1);
        chk("bp_stable", 64'(m_s), 64'(held));
        m_iv = 1'b0; m_or = 1'b1;
        n = 0;
        while (q_m.size() != 0 && n < 20) begin step(); n++; end
        chk("bp_delivered", 64'(m_pops - p0), 4);
        chk("bp_empty", 64'(m_ovld), 0);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) begin rand_main(); m_iv = 1'b1; step(); end
        m_iv = 1'b0;
        do_reset("midrst");
        rand_main();
        e = model(32, 64'(m_a), 64'(m_b), m_cin, m_sub);
        one_beat("post_rst", m_a, m_b, m_cin, m_sub, e.s[31:0], e.co, e.ov);

        // corner instances keep running on random traffic, then drain
        repeat (300) step();
        corner_run = 1'b0;
        repeat (40) step();
        chk("c8_drained", 64'(q_8.size()), 0);
        chk("c64_drained", 64'(q_64.size()), 0);
        chk("c8_traffic", 64'(c8_pops > 50), 1);
        chk("c64_traffic", 64'(c64_pops > 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
